dmem_port_arbiter: RTL and testbench
====================================

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive store grants while a load waits.
REQ-002 SHALL have port clk  input  1  single clock; all state on posedge clk.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ld_req  input  1  load request; held with payload until ld_gnt.
REQ-005 SHALL have port ld_addr  input  32  load word address.
REQ-006 SHALL have port ld_rmask  input  4  load byte read mask; nonzero when ld_req=1.
REQ-007 SHALL have port ld_gnt  output  1  one-cycle pulse; load payload captured at this edge.
REQ-008 SHALL have port ld_resp  output  1  one-cycle pulse when load data returns.
REQ-009 SHALL have port ld_rdata  output  32  dmem_rdata passthrough; valid when ld_resp=1.
REQ-010 SHALL have port st_req  input  1  committed-store request; held with payload until st_gnt.
REQ-011 SHALL have port st_addr  input  32  store word address.
REQ-012 SHALL have port st_wmask  input  4  store byte write mask; nonzero when st_req=1.
REQ-013 SHALL have port st_wdata  input  32  store data.
REQ-014 SHALL have port st_gnt  output  1  one-cycle pulse; store payload captured at this edge.
REQ-015 SHALL have port st_resp  output  1  one-cycle pulse when store completes.
REQ-016 SHALL have port flush  input  1  pipeline flush; kills an in-flight or granting load.
REQ-017 SHALL have ports dmem_addr output 32, dmem_rmask output 4, dmem_wmask output 4, dmem_wdata output 32: registered memory request.
REQ-018 SHALL have ports dmem_rdata input 32, dmem_resp input 1: memory response.
REQ-019 SHALL have port busy  output  1  high while a memory request is outstanding.

Function
REQ-020 SHALL implement FSM IDLE, BUSY_LD, BUSY_ST.
REQ-021 SHALL define accept = (state==IDLE) | dmem_resp; a grant is issued only in an accept cycle.
REQ-022 SHALL, on accept with only one requester, grant that requester.
REQ-023 SHALL, on accept with both requesting, grant the store unless starve_cnt==STARVE_LIMIT, then grant the load.
REQ-024 SHALL increment starve_cnt on each store grant while ld_req=1, and clear it on any load grant or whenever ld_req=0; the counter saturates at STARVE_LIMIT.
REQ-025 SHALL drive ld_gnt/st_gnt combinationally in the accept cycle, mutually exclusive.
REQ-026 SHALL register the granted payload to dmem_* at that edge; dmem_* are valid from the next cycle and are held stable until dmem_resp.
REQ-027 SHALL drive the unused mask to zero: for loads dmem_wmask=0; for stores dmem_rmask=0.
REQ-028 SHALL enter BUSY_LD or BUSY_ST at a grant edge; on dmem_resp with no new grant, SHALL clear dmem_rmask/dmem_wmask and enter IDLE.
REQ-029 SHALL support back-to-back operation: dmem_resp and a grant in the same cycle move directly to the new BUSY state.
REQ-030 SHALL pulse ld_resp or st_resp combinationally in the dmem_resp cycle for the BUSY owner.
REQ-031 SHALL never issue ld_gnt while flush=1.
REQ-032 SHALL, if flush=1 during BUSY_LD or in the load's dmem_resp cycle, set a kill flag; the memory access then completes normally, but ld_resp stays 0.
REQ-033 SHALL clear the kill flag on the next grant.
REQ-034 SHALL ignore flush for stores: st_resp is always delivered.
REQ-035 SHALL ignore dmem_resp in IDLE; no resp pulse is produced.
REQ-036 SHALL drive busy = (state != IDLE).

Reset
REQ-037 SHALL, on rst, asynchronously force state=IDLE, starve_cnt=0, kill=0, and dmem_addr/rmask/wmask/wdata=0.
REQ-038 SHALL hold ld_gnt, st_gnt, ld_resp, st_resp and busy at 0 during reset.
REQ-039 SHALL treat reset mid-transaction as abandoning the access; a dmem_resp after reset deassertion is ignored.

Structure
REQ-040 SHALL place the FSM state enum (arb_state_t) and a mem_req_t struct (addr, rmask, wmask, wdata) in rv32i_types.
REQ-041 SHALL be a single module with no sub-modules.

Verification
REQ-042 SHALL cover: ld_req only, addr=0x100, rmask=0xF; dmem_resp 3 cycles later with rdata=0xDEADBEEF -> ld_gnt in cycle 0, dmem_rmask=0xF in cycles 1-3, ld_resp with ld_rdata=0xDEADBEEF in cycle 3.
REQ-043 SHALL cover: ld_req and st_req both held, 1-cycle memory, STARVE_LIMIT=4 -> grants in order S,S,S,S,L.
REQ-044 SHALL cover: back-to-back stores with dmem_resp every 2nd cycle -> st_gnt in each resp cycle, with no IDLE cycle between accesses.
REQ-045 SHALL cover: flush in the cycle after ld_gnt -> dmem access completes, ld_resp=0, and the next load returns ld_resp normally.
REQ-046 SHALL cover: rst asserted during BUSY_ST -> all dmem masks are 0 immediately, and a stale dmem_resp produces no st_resp.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the data-memory port arbiter.
// Holds the arbiter state encoding and the registered memory request word.
// Imported by the arbiter; no logic lives here.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_LD = 2'd1,
    BUSY_ST = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Arbitrates one data-memory port between a load and a committed-store requester.
// Latency: grant is combinational in an accept cycle; dmem_* are registered and valid the next cycle.
// Backpressure: requesters hold payload until granted; one access outstanding, next grant rides dmem_resp.
module dmem_port_arbiter
  import rv32i_types::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [3:0]  ld_rmask,
  output logic        ld_gnt,
  output logic        ld_resp,
  output logic [31:0] ld_rdata,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [3:0]  st_wmask,
  input  logic [31:0] st_wdata,
  output logic        st_gnt,
  output logic        st_resp,
  input  logic        flush,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        busy
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_t    state_q, state_d;
  mem_req_t      req_q, req_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          kill_q, kill_d;

  logic accept;
  logic ld_ok;
  logic grant_ld;
  logic grant_st;

  // Grant selection: store wins a tie unless the waiting load has hit the starvation limit.
  always_comb begin
    accept   = (state_q == IDLE) | dmem_resp;
    ld_ok    = ld_req & ~flush;
    grant_ld = 1'b0;
    grant_st = 1'b0;
    if (accept && !rst) begin
      if (st_req && ld_ok) begin
        if (starve_q == LIMIT) grant_ld = 1'b1;
        else                   grant_st = 1'b1;
      end else if (st_req) begin
        grant_st = 1'b1;
      end else if (ld_ok) begin
        grant_ld = 1'b1;
      end
    end
  end

  // Next-state: FSM, request register, starvation counter and load-kill flag.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    starve_d = starve_q;
    kill_d   = kill_q;

    if (grant_ld) begin
      state_d = BUSY_LD;
      req_d   = '{addr: ld_addr, rmask: ld_rmask, wmask: 4'h0, wdata: 32'h0};
    end else if (grant_st) begin
      state_d = BUSY_ST;
      req_d   = '{addr: st_addr, rmask: 4'h0, wmask: st_wmask, wdata: st_wdata};
    end else if (dmem_resp && state_q != IDLE) begin
      state_d     = IDLE;
      req_d.rmask = 4'h0;
      req_d.wmask = 4'h0;
    end

    // Counts stores that jumped ahead of a waiting load; any load grant or idle load side resets it.
    if (!ld_req || grant_ld) begin
      starve_d = '0;
    end else if (grant_st && starve_q != LIMIT) begin
      starve_d = starve_q + 1'b1;
    end

    // A flushed load still finishes on the bus, but its response must be swallowed.
    if (grant_ld || grant_st) begin
      kill_d = 1'b0;
    end else if (flush && state_q == BUSY_LD) begin
      kill_d = 1'b1;
    end
  end

  // State registers with asynchronous reset that abandons any outstanding access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      starve_q <= '0;
      kill_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      starve_q <= starve_d;
      kill_q   <= kill_d;
    end
  end

  // Outputs: grants and responses are combinational; a flush in the response cycle also suppresses ld_resp.
  always_comb begin
    ld_gnt     = grant_ld;
    st_gnt     = grant_st;
    ld_resp    = ~rst & dmem_resp & (state_q == BUSY_LD) & ~kill_q & ~flush;
    st_resp    = ~rst & dmem_resp & (state_q == BUSY_ST);
    ld_rdata   = dmem_rdata;
    dmem_addr  = req_q.addr;
    dmem_rmask = req_q.rmask;
    dmem_wmask = req_q.wmask;
    dmem_wdata = req_q.wdata;
    busy       = (state_q != IDLE);
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
module tb_dmem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_req, st_req, flush, dmem_resp;
  logic [31:0] ld_addr, st_addr, st_wdata, dmem_rdata;
  logic [3:0]  ld_rmask, st_wmask;
  logic        ld_gnt, ld_resp, st_gnt, st_resp, busy;
  logic [31:0] ld_rdata, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_rmask, dmem_wmask;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_rmask(ld_rmask),
    .ld_gnt(ld_gnt), .ld_resp(ld_resp), .ld_rdata(ld_rdata),
    .st_req(st_req), .st_addr(st_addr), .st_wmask(st_wmask), .st_wdata(st_wdata),
    .st_gnt(st_gnt), .st_resp(st_resp), .flush(flush),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .busy(busy)
  );

  task automatic idle_inputs();
    ld_req = 0; st_req = 0; flush = 0; dmem_resp = 0;
    ld_addr = 0; ld_rmask = 0; st_addr = 0; st_wmask = 0; st_wdata = 0; dmem_rdata = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    ld_req = 1; ld_rmask = 4'hF; st_req = 1; st_wmask = 4'hF; dmem_resp = 1;
    #1;
    checks++; if ({ld_gnt, st_gnt, ld_resp, st_resp, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b want=00000", {ld_gnt, st_gnt, ld_resp, st_resp, busy});
    end
    @(negedge clk);
    #1;
    checks++; if ({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata} !== 72'h0) begin
      errors++; $display("FAIL reset_dmem got=%h want=0", {dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata});
    end
    checks++; if ({ld_gnt, st_gnt, busy} !== 3'b0) begin
      errors++; $display("FAIL reset_hold got=%b want=000", {ld_gnt, st_gnt, busy});
    end
    @(negedge clk);
    rst = 0;
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_single_load();
    ld_req = 1; ld_addr = 32'h100; ld_rmask = 4'hF;
    #1;
    checks++; if ({ld_gnt, st_gnt} !== 2'b10) begin
      errors++; $display("FAIL ld_gnt_c0 got=%b want=10", {ld_gnt, st_gnt});
    end
    @(negedge clk);
    idle_inputs();
    for (int c = 1; c <= 3; c++) begin
      dmem_resp = (c == 3);
      dmem_rdata = (c == 3) ? 32'hDEADBEEF : 32'h0;
      #1;
      checks++; if (dmem_rmask !== 4'hF || dmem_wmask !== 4'h0 || dmem_addr !== 32'h100 || busy !== 1'b1) begin
        errors++; $display("FAIL ld_dmem_c%0d got addr=%h rmask=%h wmask=%h busy=%b want 100/f/0/1",
                           c, dmem_addr, dmem_rmask, dmem_wmask, busy);
      end
      checks++; if (ld_resp !== (c == 3)) begin
        errors++; $display("FAIL ld_resp_c%0d got=%b want=%b", c, ld_resp, (c == 3));
      end
      if (c == 3) begin
        checks++; if (ld_rdata !== 32'hDEADBEEF) begin
          errors++; $display("FAIL ld_rdata got=%h want=deadbeef", ld_rdata);
        end
      end
      @(negedge clk);
    end
    dmem_resp = 0;
    #1;
    checks++; if (busy !== 1'b0 || dmem_rmask !== 4'h0) begin
      errors++; $display("FAIL ld_idle got busy=%b rmask=%h want 0/0", busy, dmem_rmask);
    end
    @(negedge clk);
  endtask

  task automatic test_starvation();
    logic [4:0] order;   // 1 = load grant expected, index = grant number
    order = 5'b10000;
    ld_req = 1; ld_addr = 32'h40; ld_rmask = 4'h3;
    st_req = 1; st_addr = 32'h80; st_wmask = 4'hC; st_wdata = 32'h55AA55AA;
    for (int k = 0; k < 5; k++) begin
      dmem_resp = (k > 0);
      #1;
      checks++; if ({ld_gnt, st_gnt} !== (order[k] ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL starve_grant%0d got ld/st=%b want=%b", k, {ld_gnt, st_gnt},
                           order[k] ? 2'b10 : 2'b01);
      end
      @(negedge clk);
    end
    ld_req = 0; st_req = 0; dmem_resp = 1; dmem_rdata = 32'h12345678;
    #1;
    checks++; if (ld_resp !== 1'b1 || st_resp !== 1'b0 || ld_rdata !== 32'h12345678) begin
      errors++; $display("FAIL starve_ldresp got ld=%b st=%b data=%h want 1/0/12345678", ld_resp, st_resp, ld_rdata);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    st_req = 1; st_addr = 32'h300; st_wmask = 4'hF; st_wdata = 32'h1000;
    #1;
    checks++; if (st_gnt !== 1'b1) begin
      errors++; $display("FAIL b2b_first_gnt got=%b want=1", st_gnt);
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      st_req = (k < 2); st_addr = 32'h300 + 32'(4 * (k + 1)); st_wdata = 32'h1000 + 32'(k + 1);
      dmem_resp = 0;
      #1;
      checks++; if (busy !== 1'b1 || st_gnt !== 1'b0 || dmem_wdata !== 32'h1000 + 32'(k) ||
                    dmem_addr !== 32'h300 + 32'(4 * k) || dmem_rmask !== 4'h0) begin
        errors++; $display("FAIL b2b_wait%0d got busy=%b gnt=%b addr=%h wdata=%h rmask=%h", k, busy, st_gnt,
                           dmem_addr, dmem_wdata, dmem_rmask);
      end
      @(negedge clk);
      dmem_resp = 1;
      #1;
      checks++; if (st_resp !== 1'b1 || st_gnt !== (k < 2) || busy !== 1'b1) begin
        errors++; $display("FAIL b2b_resp%0d got resp=%b gnt=%b busy=%b want 1/%b/1", k, st_resp, st_gnt, busy, (k < 2));
      end
      @(negedge clk);
    end
    idle_inputs();
    #1;
    checks++; if (busy !== 1'b0 || dmem_wmask !== 4'h0) begin
      errors++; $display("FAIL b2b_idle got busy=%b wmask=%h want 0/0", busy, dmem_wmask);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    ld_req = 1; ld_addr = 32'h200; ld_rmask = 4'h1; flush = 1;
    #1;
    checks++; if (ld_gnt !== 1'b0) begin
      errors++; $display("FAIL flush_blocks_gnt got=%b want=0", ld_gnt);
    end
    flush = 0;
    #1;
    checks++; if (ld_gnt !== 1'b1) begin
      errors++; $display("FAIL flush_ld_gnt got=%b want=1", ld_gnt);
    end
    @(negedge clk);
    ld_req = 0; flush = 1;
    #1;
    checks++; if (busy !== 1'b1 || ld_gnt !== 1'b0 || dmem_rmask !== 4'h1) begin
      errors++; $display("FAIL flush_busy got busy=%b gnt=%b rmask=%h want 1/0/1", busy, ld_gnt, dmem_rmask);
    end
    @(negedge clk);
    flush = 0; dmem_resp = 1; dmem_rdata = 32'hBAD0BAD0;
    #1;
    checks++; if (ld_resp !== 1'b0) begin
      errors++; $display("FAIL flush_killed_resp got=%b want=0", ld_resp);
    end
    @(negedge clk);
    dmem_resp = 0;
    ld_req = 1; ld_addr = 32'h204; ld_rmask = 4'h2;
    #1;
    checks++; if (busy !== 1'b0 || ld_gnt !== 1'b1) begin
      errors++; $display("FAIL flush_next_gnt got busy=%b gnt=%b want 0/1", busy, ld_gnt);
    end
    @(negedge clk);
    ld_req = 0; dmem_resp = 1; dmem_rdata = 32'h600D600D;
    #1;
    checks++; if (ld_resp !== 1'b1 || ld_rdata !== 32'h600D600D) begin
      errors++; $display("FAIL flush_next_resp got resp=%b data=%h want 1/600d600d", ld_resp, ld_rdata);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    st_req = 1; st_addr = 32'h400; st_wmask = 4'h6; st_wdata = 32'hCAFEF00D;
    @(negedge clk);
    st_req = 0;
    #1;
    checks++; if (busy !== 1'b1 || dmem_wmask !== 4'h6) begin
      errors++; $display("FAIL rstmid_busy got busy=%b wmask=%h want 1/6", busy, dmem_wmask);
    end
    rst = 1;
    #1;
    checks++; if (dmem_wmask !== 4'h0 || dmem_rmask !== 4'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_masks got wmask=%h rmask=%h busy=%b want 0/0/0", dmem_wmask, dmem_rmask, busy);
    end
    @(negedge clk);
    rst = 0;
    dmem_resp = 1;
    #1;
    checks++; if (st_resp !== 1'b0 || ld_resp !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_stale got st=%b ld=%b busy=%b want 0/0/0", st_resp, ld_resp, busy);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  // Reference model: tracks the one outstanding transaction by owner (0 none, 1 load, 2 store),
  // the count of stores granted ahead of a waiting load, and whether the current load was flushed.
  task automatic test_random();
    int          owner = 0, starve = 0, wait_n = 0;
    bit          killed = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [3:0]  m_rmask = 0, m_wmask = 0;
    bit          lp = 0, sp = 0, accept, ld_can, eg_ld, eg_st, er_ld, er_st;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!lp && ($urandom % 3 == 0)) begin
        lp = 1; ld_addr = $urandom; ld_rmask = 4'($urandom_range(1, 15));
      end
      if (!sp && ($urandom % 3 == 0)) begin
        sp = 1; st_addr = $urandom; st_wmask = 4'($urandom_range(1, 15)); st_wdata = $urandom;
      end
      ld_req = lp; st_req = sp;
      flush = ($urandom % 8 == 0);
      dmem_resp = (owner != 0) ? (wait_n == 0) : ($urandom % 6 == 0);
      dmem_rdata = $urandom;
      #1;
      accept = (owner == 0) || dmem_resp;
      ld_can = lp && !flush;
      eg_ld = accept && ld_can && (!sp || starve >= LIMIT);
      eg_st = accept && sp && !eg_ld;
      er_ld = dmem_resp && owner == 1 && !killed && !flush;
      er_st = dmem_resp && owner == 2;
      checks++; if ({ld_gnt, st_gnt, ld_resp, st_resp} !== {eg_ld, eg_st, er_ld, er_st}) begin
        errors++; $display("FAIL rnd_ctrl cyc=%0d got gnt/resp=%b want=%b", cyc,
                           {ld_gnt, st_gnt, ld_resp, st_resp}, {eg_ld, eg_st, er_ld, er_st});
      end
      checks++; if (busy !== (owner != 0) || dmem_addr !== m_addr || dmem_rmask !== m_rmask ||
                    dmem_wmask !== m_wmask || dmem_wdata !== m_wdata) begin
        errors++; $display("FAIL rnd_dmem cyc=%0d got busy=%b %h/%h/%h/%h want %b %h/%h/%h/%h", cyc, busy,
                           dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata, owner != 0, m_addr, m_rmask, m_wmask, m_wdata);
      end
      if (er_ld) begin
        checks++; if (ld_rdata !== dmem_rdata) begin
          errors++; $display("FAIL rnd_rdata cyc=%0d got=%h want=%h", cyc, ld_rdata, dmem_rdata);
        end
      end
      if (!lp || eg_ld) starve = 0;
      else if (eg_st && starve < LIMIT) starve = starve + 1;
      if (eg_ld || eg_st) killed = 0;
      else if (flush && owner == 1) killed = 1;
      if (eg_ld) begin
        owner = 1; m_addr = ld_addr; m_rmask = ld_rmask; m_wmask = 0; m_wdata = 0;
        lp = 0; wait_n = $urandom_range(0, 2);
      end else if (eg_st) begin
        owner = 2; m_addr = st_addr; m_rmask = 0; m_wmask = st_wmask; m_wdata = st_wdata;
        sp = 0; wait_n = $urandom_range(0, 2);
      end else if (owner != 0 && dmem_resp) begin
        owner = 0; m_rmask = 0; m_wmask = 0;
      end else if (owner != 0) begin
        wait_n = wait_n - 1;
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_starvation();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
